// File: rtl/seq_scan_arb.sv
// seq_scan_arb: round-robin front end feeding one shared
// serial pattern-count engine for NCH bit sources.
module seq_scan_arb #(
  parameter int NCH = 4,
  parameter int PLEN = 4,
  parameter logic [PLEN-1:0] PATTERN = 4'b0110,
  parameter int FRAME_LEN = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NCH-1:0]   req,
  input  logic [NCH-1:0]   bit_valid,
  input  logic [NCH-1:0]   bit_data,
  output logic [NCH-1:0]   grant,
  output logic             bit_ready,
  output logic             done,
  output logic [NCH-1:0]   done_grant,
  output logic [CNT_W-1:0] match_cnt,
  output logic             aborted
);

  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int BW = 8;
  localparam logic [NCH-1:0] ONE = NCH'(1);
  localparam logic [CNT_W-1:0] CMAX = '1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    REPORT
  } state_t;

  state_t state, state_nx;

  logic [IW-1:0]    gidx;
  logic [IW-1:0]    last_grant;
  logic [IW-1:0]    pick_idx;
  logic             found;
  logic [BW-1:0]    bcnt;
  logic [BW-1:0]    bcnt_inc;
  logic [PLEN-1:0]  hist;
  logic [PLEN-1:0]  hist_nx;
  logic [CNT_W-1:0] mcnt;
  logic [CNT_W-1:0] mcnt_nx;
  logic             load;
  logic             accept;
  logic             stop;
  logic             hit;
  logic             rep;

  // rotating search starting just after the last channel served
  always_comb begin
    found = 1'b0;
    pick_idx = last_grant;
    for (int i = 1; i <= NCH; i++) begin
      if (!found && req[(int'(last_grant) + i) % NCH]) begin
        found = 1'b1;
        pick_idx = IW'((int'(last_grant) + i) % NCH);
      end
    end
  end

  // shift/compare view of the bit being offered this cycle
  always_comb begin
    bcnt_inc = bcnt + BW'(1);
    hist_nx = {hist[PLEN-2:0], bit_data[gidx]};
    hit = accept && (bcnt_inc >= BW'(PLEN)) &&
          (hist_nx == PATTERN);
    mcnt_nx = (hit && mcnt != CMAX) ? mcnt + CNT_W'(1) : mcnt;
  end

  // next state and control strobes; abort wins over accept
  always_comb begin
    state_nx = state;
    load = 1'b0;
    accept = 1'b0;
    stop = 1'b0;
    unique case (state)
      IDLE: begin
        if (found) begin
          load = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        if (!req[gidx]) begin
          stop = 1'b1;
          state_nx = REPORT;
        end else if (bit_valid[gidx]) begin
          accept = 1'b1;
          if (bcnt_inc == BW'(FRAME_LEN))
            state_nx = REPORT;
        end
      end
      REPORT: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    rep = (state == RUN) && (state_nx == REPORT);
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end

  // frame datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gidx <= '0;
      last_grant <= IW'(NCH - 1);
      bcnt <= '0;
      hist <= '0;
      mcnt <= '0;
      grant <= '0;
      bit_ready <= 1'b0;
      done <= 1'b0;
      done_grant <= '0;
      match_cnt <= '0;
      aborted <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        gidx <= pick_idx;
        grant <= ONE << pick_idx;
        bit_ready <= 1'b1;
        bcnt <= '0;
        hist <= '0;
        mcnt <= '0;
      end
      if (accept) begin
        hist <= hist_nx;
        bcnt <= bcnt_inc;
        mcnt <= mcnt_nx;
      end
      if (rep) begin
        done <= 1'b1;
        done_grant <= grant;
        match_cnt <= mcnt_nx;
        aborted <= stop;
        last_grant <= gidx;
        grant <= '0;
        bit_ready <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seq_scan_arb.sv
// tb_seq_scan_arb: directed frames with a scoreboard
// checking every done report on two counter widths.
module tb_seq_scan_arb;

  logic clk;
  logic rst_n;
  logic [3:0] req;
  logic [3:0] bit_valid;
  logic [3:0] bit_data;

  logic [3:0] grant1, dg1;
  logic       br1, done1, ab1;
  logic [4:0] mc1;
  logic [3:0] grant2, dg2;
  logic       br2, done2, ab2;
  logic [1:0] mc2;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int req_cyc = 0;
  int done_cyc = 0;

  typedef struct packed {
    logic [3:0] g;
    logic [4:0] c;
    logic       a;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  exp_t e1, e2;

  seq_scan_arb dut1 (
    .clk(clk), .rst_n(rst_n), .req(req),
    .bit_valid(bit_valid), .bit_data(bit_data),
    .grant(grant1), .bit_ready(br1), .done(done1),
    .done_grant(dg1), .match_cnt(mc1), .aborted(ab1)
  );

  seq_scan_arb #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .req(req),
    .bit_valid(bit_valid), .bit_data(bit_data),
    .grant(grant2), .bit_ready(br2), .done(done2),
    .done_grant(dg2), .match_cnt(mc2), .aborted(ab2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  function automatic void expect_frame(input logic [3:0] g,
                                       input int c,
                                       input logic a);
    exp_t x;
    x.g = g; x.c = 5'(c); x.a = a;
    q1.push_back(x);
    x.c = 5'((c > 3) ? 3 : c);
    q2.push_back(x);
  endfunction

  // monitor for the wide-counter instance
  always @(negedge clk) begin
    chk("onehot1", 32'($onehot0(grant1)), 32'd1);
    if (done1) begin
      if (q1.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_done1 grant=%b", dg1);
      end else begin
        e1 = q1.pop_front();
        chk("done_grant1", 32'(dg1), 32'(e1.g));
        chk("match_cnt1", 32'(mc1), 32'(e1.c));
        chk("aborted1", 32'(ab1), 32'(e1.a));
        chk("grant_off1", 32'(grant1), 32'd0);
        done_cyc = cyc;
      end
    end
  end

  // monitor for the 2-bit saturating instance
  always @(negedge clk) begin
    if (done2) begin
      if (q2.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_done2 grant=%b", dg2);
      end else begin
        e2 = q2.pop_front();
        chk("done_grant2", 32'(dg2), 32'(e2.g));
        chk("match_cnt2", 32'(mc2), 32'(e2.c));
        chk("aborted2", 32'(ab2), 32'(e2.a));
      end
    end
  end

  task automatic wait_grant(input int ch);
    bit ok;
    ok = 0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (grant1[ch]) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL grant_timeout ch=%0d got=%b", ch, grant1);
    end
  endtask

  // nb bits MSB-first from ch; nb<16 ends with a req drop
  task automatic frame(input int ch, input logic [15:0] bits,
                       input int nb, input bit bub,
                       input bit noise);
    int i;
    bit tg;
    @(negedge clk);
    req = '0;
    req[ch] = 1'b1;
    req_cyc = cyc;
    wait_grant(ch);
    i = 0;
    tg = 0;
    for (int t = 0; t < 200 && i < nb; t++) begin
      bit_valid = '0;
      bit_data = '0;
      if (!bub || tg) begin
        bit_valid[ch] = 1'b1;
        bit_data[ch] = bits[15-i];
        i++;
      end
      if (noise) begin
        bit_valid[3] = ~tg;
        bit_data[3] = 1'b1;
      end
      tg = ~tg;
      @(negedge clk);
    end
    bit_valid = '0;
    bit_data = '0;
    req = '0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int n;
    logic [15:0] pat;
    req = '0;
    bit_valid = '0;
    bit_data = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_grant", 32'(grant1), 32'd0);
    chk("rst_ready", 32'(br1), 32'd0);
    chk("rst_done", 32'(done1), 32'd0);
    chk("rst_done_grant", 32'(dg1), 32'd0);
    chk("rst_match_cnt", 32'(mc1), 32'd0);
    chk("rst_aborted", 32'(ab1), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // round robin with all channels requesting, all-zero data
    expect_frame(4'b0001, 0, 1'b0);
    expect_frame(4'b0010, 0, 1'b0);
    expect_frame(4'b0100, 0, 1'b0);
    expect_frame(4'b1000, 0, 1'b0);
    expect_frame(4'b0001, 0, 1'b0);
    req = 4'hF;
    bit_valid = 4'hF;
    bit_data = 4'h0;
    n = 0;
    for (int t = 0; t < 200 && n < 5; t++) begin
      @(negedge clk);
      if (done1) n++;
    end
    req = '0;
    bit_valid = '0;
    chk("rr_frames", 32'(n), 32'd5);
    repeat (2) @(negedge clk);

    // 0110110 + nine zeros: two overlapping matches
    expect_frame(4'b0001, 2, 1'b0);
    frame(0, 16'h6C00, 16, 1'b0, 1'b0);
    // done lands in the 18th cycle counting the req cycle
    chk("latency", 32'(done_cyc - req_cyc), 32'd17);

    // ch2 aborts after 0,1,1,0,0
    expect_frame(4'b0100, 1, 1'b1);
    frame(2, 16'h6000, 5, 1'b0, 1'b0);

    // repeating 0110: 4 matches, 3 on the 2-bit counter
    expect_frame(4'b1000, 4, 1'b0);
    frame(3, 16'h6666, 16, 1'b0, 1'b0);

    // leading 110 must not match against the cleared history
    expect_frame(4'b0010, 0, 1'b0);
    frame(1, 16'hC000, 16, 1'b0, 1'b0);

    // ch1 every other cycle, ch3 strobing noise
    expect_frame(4'b0010, 2, 1'b0);
    frame(1, 16'h6C00, 16, 1'b1, 1'b1);

    // async reset after 8 bits on ch2
    @(negedge clk);
    req = 4'b0100;
    wait_grant(2);
    pat = 16'h6666;
    for (int i = 0; i < 8; i++) begin
      bit_valid = 4'b0100;
      bit_data = '0;
      bit_data[2] = pat[15-i];
      @(negedge clk);
    end
    rst_n = 1'b0;
    req = '0;
    bit_valid = '0;
    bit_data = '0;
    #1;
    chk("arst_grant", 32'(grant1), 32'd0);
    chk("arst_ready", 32'(br1), 32'd0);
    chk("arst_done", 32'(done1), 32'd0);
    chk("arst_done_grant", 32'(dg1), 32'd0);
    chk("arst_match_cnt", 32'(mc1), 32'd0);
    chk("arst_aborted", 32'(ab1), 32'd0);
    chk("arst_match_cnt2", 32'(mc2), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    req = 4'b0101;
    wait_grant(0);
    chk("rr_after_reset", 32'(grant1), 32'h1);
    expect_frame(4'b0001, 0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      bit_valid = 4'b0001;
      bit_data = '0;
      @(negedge clk);
    end
    req = '0;
    bit_valid = '0;
    repeat (4) @(negedge clk);

    chk("q1_empty", 32'(q1.size()), 32'd0);
    chk("q2_empty", 32'(q2.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
